// File: rtl/sdram_pll_reset_seq_if.sv
// Control/status bundle between the PLL reset sequencer and the PLL / SDRAM side.
// Latency: n/a (wires only).
// Backpressure: none; all signals are levels.
//
// Signals:
//   pll_locked    PLL lock indication, asynchronous to refclk
//   pll_rst       PLL reset, registered
//   sys_rst       system reset to the SDRAM controller and core, active-high
//   ready         high while the sequencer is in RUN
//   relock_count  lock losses seen in RUN, saturating at 255
//   timeout_err   sticky lock-timeout flag
// master = the sequencer, slave = the PLL / consumer side.
interface sdram_pll_reset_seq_if;
    logic       pll_locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] relock_count;
    logic       timeout_err;

    modport master (
        input  pll_locked,
        output pll_rst,
        output sys_rst,
        output ready,
        output relock_count,
        output timeout_err
    );

    modport slave (
        output pll_locked,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  relock_count,
        input  timeout_err
    );
endinterface

// File: rtl/sdram_pll_reset_seq.sv
// PLL reset sequencer / lock monitor: pulses pll_rst, waits for lock, releases sys_rst after stable lock.
// Latency: pll_locked edge reaches the state 3 refclk edges later; outputs are registered off the next state.
// Backpressure: none; outputs are levels.
//
// Ports: refclk (only clock), rst (sync, active-high), pll_if (master modport of sdram_pll_reset_seq_if).
// Optional feature: define PLL_SEQ_RELOCK_EN to re-sequence the PLL on lock loss in RUN and count relocks;
// without it, lock loss parks the block in LOCK_LOST until rst.
module sdram_pll_reset_seq #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65535
) (
    input  logic                  refclk,
    input  logic                  rst,
    sdram_pll_reset_seq_if.master pll_if
);

    localparam int MAX_AB = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_C  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W  = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        LOCK_LOST = 3'd4
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             sync1, lk;
    logic             pll_rst_q, sys_rst_q, ready_q, timeout_err_q;
    logic             timeout_set;
`ifdef PLL_SEQ_RELOCK_EN
    logic             relock_inc;
    logic [7:0]       relock_q;
`endif

    // Next-state logic. Lock is tested before timeout in WAIT_LOCK so a
    // lock arriving on the last timeout cycle still wins.
    always_comb begin
        state_nxt   = state;
        timeout_set = 1'b0;
`ifdef PLL_SEQ_RELOCK_EN
        relock_inc  = 1'b0;
`endif
        case (state)
            PLL_RESET: if (cnt == RST_LAST) state_nxt = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lk) begin
                    state_nxt = STABILIZE;
                end else if (cnt == TMO_LAST) begin
                    state_nxt   = PLL_RESET;
                    timeout_set = 1'b1;
                end
            end
            STABILIZE: begin
                if (!lk)                     state_nxt = WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = RUN;
            end
            RUN: begin
                if (!lk) begin
`ifdef PLL_SEQ_RELOCK_EN
                    state_nxt  = PLL_RESET;
                    relock_inc = 1'b1;
`else
                    state_nxt  = LOCK_LOST;
`endif
                end
            end
            LOCK_LOST: state_nxt = LOCK_LOST;
            default:   state_nxt = PLL_RESET;
        endcase

        // Counter clears on any state change; RUN and LOCK_LOST do not
        // count so it never wraps while parked there.
        cnt_nxt = cnt;
        if (state_nxt != state)
            cnt_nxt = '0;
        else if (state == PLL_RESET || state == WAIT_LOCK || state == STABILIZE)
            cnt_nxt = cnt + CNT_W'(1);
    end

    // Outputs are registered decodes of the next state so they change on
    // the same edge as the state register.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state         <= PLL_RESET;
            cnt           <= '0;
            sync1         <= 1'b0;
            lk            <= 1'b0;
            pll_rst_q     <= 1'b1;
            sys_rst_q     <= 1'b1;
            ready_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            sync1         <= pll_if.pll_locked;
            lk            <= sync1;
            pll_rst_q     <= (state_nxt == PLL_RESET);
            sys_rst_q     <= (state_nxt != RUN);
            ready_q       <= (state_nxt == RUN);
            timeout_err_q <= timeout_err_q | timeout_set;
        end
    end

`ifdef PLL_SEQ_RELOCK_EN
    always_ff @(posedge refclk) begin
        if (rst)
            relock_q <= 8'd0;
        else if (relock_inc && relock_q != 8'hFF)
            relock_q <= relock_q + 8'd1;
    end
    assign pll_if.relock_count = relock_q;
`else
    assign pll_if.relock_count = 8'd0;
`endif

    assign pll_if.pll_rst     = pll_rst_q;
    assign pll_if.sys_rst     = sys_rst_q;
    assign pll_if.ready       = ready_q;
    assign pll_if.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sdram_pll_reset_seq.sv
// Directed bench for sdram_pll_reset_seq. Stimulus pushes the expected output
// change events (edge index + output vector) into a queue; a monitor pops one
// entry every time the DUT output vector changes and compares.
module tb_sdram_pll_reset_seq;
    localparam int P = 4;
    localparam int S = 8;
    localparam int T = 32;
    // {pll_rst, sys_rst, ready, relock_count[7:0], timeout_err}
    localparam logic [11:0] RESETV = 12'b1_1_0_00000000_0;

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    sdram_pll_reset_seq_if bus();

    sdram_pll_reset_seq #(
        .PLL_RST_CYCLES(P),
        .LOCK_STABLE_CYCLES(S),
        .LOCK_TIMEOUT_CYCLES(T)
    ) dut (
        .refclk(refclk),
        .rst(rst),
        .pll_if(bus)
    );

    always #10 refclk = ~refclk;

    // cyc = number of rising edges so far
    int cyc = 0;
    always @(posedge refclk) cyc <= cyc + 1;

    typedef struct {
        int          c;
        logic [11:0] v;
    } ev_t;

    ev_t         q[$];
    ev_t         e;
    int          checks = 0;
    int          errors = 0;
    int          base;
    int          x;
    logic [11:0] prev, cur;
    bit          first = 1'b1;

    function automatic logic [11:0] mk(logic p, logic s, logic r, logic [7:0] rc, logic t);
        return {p, s, r, rc, t};
    endfunction

    task automatic push(int c, logic [11:0] v);
        ev_t n;
        n.c = c;
        n.v = v;
        q.push_back(n);
    endtask

    task automatic wait_cyc(int c);
        while (cyc < c) @(negedge refclk);
    endtask

    // One-cycle rst pulse; lock input set alongside. base = edge index of the reset edge.
    task automatic do_reset(logic lkv);
        rst = 1'b1;
        bus.pll_locked = lkv;
        @(negedge refclk);
        rst = 1'b0;
        base = cyc;
        push(base, RESETV);
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge refclk);
            #1;
            cur = {bus.pll_rst, bus.sys_rst, bus.ready, bus.relock_count, bus.timeout_err};
            if (first || cur !== prev) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change at edge %0d: got %h, required no change", cyc, cur);
                end else begin
                    e = q.pop_front();
                    if (e.c != cyc || e.v !== cur) begin
                        errors++;
                        $display("FAIL output_event: got edge %0d vec %h, required edge %0d vec %h",
                                 cyc, cur, e.c, e.v);
                    end
                end
            end
            prev  = cur;
            first = 1'b0;
        end
    end

    // Stimulus
    initial begin
        bus.pll_locked = 1'b0;
        push(1, RESETV);
        @(negedge refclk);
        wait_cyc(3);
        rst  = 1'b0;
        base = cyc;

        // Power-up: lock rises 10 cycles after rst falls
        push(base + 4,  mk(0, 1, 0, 8'd0, 0));
        push(base + 21, mk(0, 0, 1, 8'd0, 0));
        wait_cyc(base + 10);
        bus.pll_locked = 1'b1;
        wait_cyc(base + 30);

        // Lock reaches lk on the same cycle the timeout count expires: lock wins
        do_reset(1'b0);
        push(base + 4,  mk(0, 1, 0, 8'd0, 0));
        push(base + 44, mk(0, 0, 1, 8'd0, 0));
        wait_cyc(base + 33);
        bus.pll_locked = 1'b1;
        wait_cyc(base + 50);

        // Timeout: lock never arrives, pll_rst re-pulses every 36 cycles
        do_reset(1'b0);
        push(base + 4,  mk(0, 1, 0, 8'd0, 0));
        push(base + 36, mk(1, 1, 0, 8'd0, 1));
        push(base + 40, mk(0, 1, 0, 8'd0, 1));
        push(base + 72, mk(1, 1, 0, 8'd0, 1));
        push(base + 76, mk(0, 1, 0, 8'd0, 1));
        wait_cyc(base + 80);

        // Glitchy lock: high 5, low 3, then high
        do_reset(1'b0);
        push(base + 4,  mk(0, 1, 0, 8'd0, 0));
        push(base + 29, mk(0, 0, 1, 8'd0, 0));
        wait_cyc(base + 10);
        bus.pll_locked = 1'b1;
        wait_cyc(base + 15);
        bus.pll_locked = 1'b0;
        wait_cyc(base + 18);
        bus.pll_locked = 1'b1;
        wait_cyc(base + 35);

        // Mid-sequence reset: timeout first, then rst in STABILIZE with cnt=5
        do_reset(1'b0);
        push(base + 4,  mk(0, 1, 0, 8'd0, 0));
        push(base + 36, mk(1, 1, 0, 8'd0, 1));
        push(base + 40, mk(0, 1, 0, 8'd0, 1));
        wait_cyc(base + 41);
        bus.pll_locked = 1'b1;
        wait_cyc(base + 49);
        do_reset(1'b1);
        push(base + 4,  mk(0, 1, 0, 8'd0, 0));
        push(base + 13, mk(0, 0, 1, 8'd0, 0));
        wait_cyc(base + 20);

        // Lock loss in RUN
        x = cyc;
`ifdef PLL_SEQ_RELOCK_EN
        for (int i = 0; i < 300; i++) begin
            logic [7:0] rc;
            rc = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            push(x + 3,  mk(1, 1, 0, rc, 0));
            push(x + 7,  mk(0, 1, 0, rc, 0));
            push(x + 31, mk(0, 0, 1, rc, 0));
            bus.pll_locked = 1'b0;
            wait_cyc(x + 20);
            bus.pll_locked = 1'b1;
            wait_cyc(x + 40);
            x = x + 40;
        end
        do_reset(1'b0);
        wait_cyc(base + 10);
`else
        push(x + 3, mk(0, 1, 0, 8'd0, 0));
        bus.pll_locked = 1'b0;
        wait_cyc(x + 20);
        bus.pll_locked = 1'b1;
        wait_cyc(x + 60);
        do_reset(1'b0);
        push(base + 4,  mk(0, 1, 0, 8'd0, 0));
        push(base + 21, mk(0, 0, 1, 8'd0, 0));
        wait_cyc(base + 10);
        bus.pll_locked = 1'b1;
        wait_cyc(base + 30);
`endif

        wait_cyc(cyc + 10);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d unobserved, required 0 (next edge %0d vec %h)",
                     q.size(), q[0].c, q[0].v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sdram_pll_reset_seq.md
# sdram_pll_reset_seq

Reset sequencer and lock monitor on the control side of the SDRAM controller's PLL. It drives the PLL reset and consumes the PLL lock indication. System reset for the SDRAM controller and the core is released only after lock has been continuously stable for a programmable interval. Runs in the 50 MHz reference clock domain, the only clock guaranteed to exist while the PLL is unlocked.

## Interface
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per PLL reset pulse (≥1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronized-lock-high cycles required before system reset release (≥1).
- LOCK_TIMEOUT_CYCLES, 65535: maximum cycles in WAIT_LOCK before the PLL is reset again (≥1).
- refclk  in  1  free-running 50 MHz reference clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- pll_locked  in  1  PLL lock, asynchronous to refclk.
- pll_rst  out  1  PLL reset, registered.
- sys_rst  out  1  system reset to the SDRAM controller and core, active-high, registered.
- ready  out  1  high exactly when the state is RUN.
- relock_count  out  8  number of lock losses seen in RUN; saturates at 255.
- timeout_err  out  1  sticky: a WAIT_LOCK timeout has occurred.

## Operation
- `pll_locked` passes through a 2-flop synchronizer. All decisions use the synchronizer output `lk`.
- A single counter `cnt` is sized to the largest parameter. It clears on every state change.
- All outputs are registered and derived from the state register.
- Reset values: state PLL_RESET, `cnt`=0, synchronizer=0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `relock_count`=0, `timeout_err`=0.
- PLL_RESET (`pll_rst`=1, `sys_rst`=1): when `cnt` reaches PLL_RST_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK (`pll_rst`=0, `sys_rst`=1):
  - `lk`=1 → STABILIZE.
  - Otherwise, when `cnt` reaches LOCK_TIMEOUT_CYCLES-1 → set `timeout_err`, go to PLL_RESET.
  - If both happen in the same cycle, lock wins.
- STABILIZE (`sys_rst`=1):
  - `lk`=0 → WAIT_LOCK; the timeout count restarts from 0.
  - `lk`=1 for LOCK_STABLE_CYCLES consecutive cycles, the first being the cycle STABILIZE is entered → RUN.
- RUN (`sys_rst`=0, `ready`=1): on `lk`=0, `sys_rst` reasserts on the next edge; the next state depends on configuration.
- `rst` asserted in any state, including mid-count, returns the block to reset values on the next edge. `rst` overrides every other transition.

## Timing
- First edge with `rst` low = cycle 0. `pll_rst` falls at the edge ending cycle PLL_RST_CYCLES-1.
- A `pll_locked` rising edge reaches `lk` 2 edges later, and the state enters STABILIZE 1 edge after that.
- From STABILIZE entry, `sys_rst` falls and `ready` rises after exactly LOCK_STABLE_CYCLES edges.
- Minimum time from `pll_locked` rising to `sys_rst` falling: 3 + LOCK_STABLE_CYCLES edges.
- Lock loss in RUN: `sys_rst` rises 3 edges after the `pll_locked` falling edge (2 synchronizer edges + 1 state edge).
- Glitches on `pll_locked` shorter than one refclk period may be missed. This is acceptable because STABILIZE filters them.

## Configuration
- `PLL_SEQ_RELOCK_EN` defined:
  - Lock loss in RUN → PLL_RESET, a full re-sequence.
  - `relock_count` increments in the same cycle, saturating at 255.
- `PLL_SEQ_RELOCK_EN` undefined:
  - Lock loss in RUN → terminal state LOCK_LOST: `pll_rst`=0, `sys_rst`=1, `ready`=0. Only `rst` leaves it.
  - `relock_count` is held at 0 and its counter logic is removed.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32.
- Power-up: `pll_locked` rises 10 cycles after `rst` falls and stays high. Required: `pll_rst` falls at cycle 4; `sys_rst` falls and `ready` rises 11 edges after the `pll_locked` rise; `timeout_err`=0.
- Timeout: `pll_locked` held 0. Required: `timeout_err` sets; `pll_rst` re-pulses high for 4 cycles every 36 cycles; `sys_rst` stays 1.
- Glitchy lock: `pll_locked` high for 5 cycles, low for 3, then high. Required: `sys_rst` stays 1 through the glitch and falls only after 8 uninterrupted `lk`-high cycles.
- Relock, macro defined: in RUN, drop `pll_locked` for 20 cycles, then restore. Required: `sys_rst`=1 three edges after the drop; `relock_count`=1; a 4-cycle `pll_rst` pulse; RUN reached again. Repeat 300 times → `relock_count`=255.
- Relock, macro undefined: the same drop. Required: `sys_rst`=1 and `ready`=0 stay set after lock returns; `relock_count`=0; `rst` restarts the full sequence.
- Mid-sequence reset: assert `rst` for 1 cycle in STABILIZE with `cnt`=5. Required: all outputs return to reset values next edge; `timeout_err` clears; the sequence restarts from cycle 0.
